injetor_seq: RTL and testbench
==============================

Name: injetor_seq

Overview:
- Parametrised, pipelined error injector for Hamming codeword streams.
- Sits between the encoder and the decoder/corrector in lab datapaths.
- Accepts words over a valid/ready handshake and XORs a configurable error mask into each injection slot.
- Modes: single, double, burst and pseudo-random single-bit errors. A period counter and a running injection count make decoder coverage runs repeatable.

Parameters:
- WIDTH, 15: codeword width in bits.
- POS_W, 4: bit-position field width. Must equal clog2(WIDTH).
- CNT_W, 16: width of the injected-word counter.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- erro  in  1  global injection enable.
- modo  in  3  injection mode.
- n  in  POS_W  first bit position.
- m  in  POS_W  second bit position (DOUBLE mode).
- burst_len  in  POS_W  burst length (BURST mode).
- periodo  in  8  injection period in accepted words; 0 = every word.
- entrada_valid  in  1  input word valid.
- entrada  in  WIDTH  input codeword.
- entrada_ready  out  1  block can accept a word.
- saida_valid  out  1  output word valid.
- saida  out  WIDTH  entrada XOR mask.
- saida_ready  in  1  downstream accepts the output.
- mascara  out  WIDTH  mask applied to the current output word.
- injetado  out  1  mascara != 0 for the current output word.
- total_injetado  out  CNT_W  count of words with a nonzero mask; saturates.

Behaviour:
- Reset (sync, active-high):
  - saida_valid=0, saida=0, mascara=0, injetado=0, total_injetado=0.
  - Period counter=0, LFSR=LFSR_SEED.
  - A word held at reset is discarded.
- Handshake:
  - entrada_ready = !saida_valid || saida_ready (combinational).
  - Accept = entrada_valid && entrada_ready. Latency 1 cycle.
  - While saida_valid && !saida_ready: saida, mascara and injetado stay stable.
  - No words are dropped or duplicated; order is preserved.
- Configuration sampling: erro, modo, n, m, burst_len and periodo are sampled only on the accept cycle.
- Period counter (cnt, 8 bit):
  - Advances on every accept, independent of erro.
  - periodo=0: every word is a slot; cnt held at 0.
  - Otherwise the word is a slot when cnt==periodo-1; cnt then wraps to 0, else it increments.
  - A change of periodo while cnt >= periodo takes effect after cnt wraps through 255.
- Mask: applied only when erro=1 and the word is a slot; otherwise mask=0.
  - 0 NENHUM: mask 0.
  - 1 SIMPLES: bit n. If n >= WIDTH, mask 0.
  - 2 DUPLO: bits n and m, OR-combined (n==m gives a single bit). Out-of-range positions are ignored individually.
  - 3 RAJADA: bits n .. n+burst_len-1, truncated at WIDTH-1 with no wrap. burst_len=0 gives mask 0.
  - 4 ALEATORIO: position p = lfsr[POS_W-1:0]; if p >= WIDTH, then p = p-WIDTH. Uses the LFSR value before advancing.
  - 5-7: reserved, mask 0.
- LFSR (16 bit, Fibonacci):
  - fb = l[15]^l[13]^l[12]^l[10]; next l = {l[14:0], fb}.
  - Steps once per accept in every mode.
- total_injetado: +1 on accept when mask != 0; holds at all-ones.
- injetado is registered together with saida.

Decomposition:
- Package injetor_pkg:
  - Mode localparams MODO_NENHUM=0, MODO_SIMPLES=1, MODO_DUPLO=2, MODO_RAJADA=3, MODO_ALEATORIO=4.
  - Default LFSR seed and tap constants.
- Sub-module injetor_lfsr:
  - Ports: clk, rst, avanca, estado[15:0].
  - Parameter SEED.

Test Plan:
- Passthrough and single flip:
  - Stimulus: reset; erro=0, modo=1, n=14, periodo=0, entrada=15'h0000. Response: saida=15'h0000, injetado=0.
  - Stimulus: erro=1, same word. Response: saida=15'h4000, mascara=15'h4000, total_injetado=1.
- DUPLO:
  - n=3, m=3, entrada=15'h7FFF -> saida=15'h7FF7.
  - n=3, m=15 -> mascara=15'h0008.
  - n=2, m=9 -> mascara=15'h0204.
- RAJADA: n=12, burst_len=5, entrada=0 -> mascara=15'h7000 (truncated at bit 14); burst_len=0 -> mascara=0.
- Period: periodo=4, modo=1, n=0, 8 back-to-back zero words -> words 4 and 8 have saida=15'h0001; total_injetado=2.
- Backpressure:
  - Stimulus: saida_ready=0 for 3 cycles with entrada_valid=1. Response: entrada_ready=0; saida and mascara stable; total_injetado not incremented again.
  - Stimulus: release. Response: all words appear in order.
- ALEATORIO, seed 16'hACE1:
  - First accepted word -> mascara=15'h0002.
  - Second word (LFSR=16'h59C3) -> mascara=15'h0008.
  - Stimulus: assert rst mid-stream. Response: the LFSR restarts, so the next word again gets 15'h0002.

Source files
------------

// File: rtl/injetor_pkg.sv
// ---------------------------------------------------------------------------
// injetor_pkg
// Shared constants for the Hamming-codeword error injector:
//   - injection mode codes (value carried on the 3-bit 'modo' port)
//   - default LFSR seed and feedback tap mask
//   - lfsr_next(): one step of the 16-bit Fibonacci LFSR
// ---------------------------------------------------------------------------
package injetor_pkg;

    localparam logic [2:0] MODO_NENHUM    = 3'd0;
    localparam logic [2:0] MODO_SIMPLES   = 3'd1;
    localparam logic [2:0] MODO_DUPLO     = 3'd2;
    localparam logic [2:0] MODO_RAJADA    = 3'd3;
    localparam logic [2:0] MODO_ALEATORIO = 3'd4;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = ^(l & LFSR_TAPS);
        return {l[14:0], fb};
    endfunction

endpackage

// File: rtl/injetor_lfsr.sv
// ---------------------------------------------------------------------------
// injetor_lfsr
// 16-bit Fibonacci LFSR used to pick pseudo-random error positions.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, loads SEED
//   avanca  in   advance one step this cycle
//   estado  out  current LFSR value
// ---------------------------------------------------------------------------
module injetor_lfsr
    import injetor_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avanca,
    output logic [15:0] estado
);

    logic [15:0] estado_q;
    logic [15:0] estado_d;

    always_comb begin
        estado_d = estado_q;
        if (avanca) begin
            estado_d = lfsr_next(estado_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= SEED;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign estado = estado_q;

endmodule

// File: rtl/injetor_seq.sv
// ---------------------------------------------------------------------------
// injetor_seq
// Pipelined error injector for Hamming codeword streams. Each accepted word
// is XORed with an error mask chosen by 'modo' when injection is enabled and
// the word falls on a period slot. One register stage, valid/ready handshake.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   erro             global injection enable        (sampled on accept)
//   modo             injection mode                 (sampled on accept)
//   n, m             first / second bit position    (sampled on accept)
//   burst_len        burst length                   (sampled on accept)
//   periodo          slot period in words, 0 = all  (sampled on accept)
//   entrada_valid/entrada/entrada_ready  input word handshake
//   saida_valid/saida/saida_ready        output word handshake
//   mascara          mask applied to the current output word
//   injetado         mascara != 0 for the current output word
//   total_injetado   saturating count of words that received a nonzero mask
// ---------------------------------------------------------------------------
module injetor_seq
    import injetor_pkg::*;
#(
    parameter int unsigned WIDTH     = 15,
    parameter int unsigned POS_W     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             erro,
    input  logic [2:0]       modo,
    input  logic [POS_W-1:0] n,
    input  logic [POS_W-1:0] m,
    input  logic [POS_W-1:0] burst_len,
    input  logic [7:0]       periodo,
    input  logic             entrada_valid,
    input  logic [WIDTH-1:0] entrada,
    output logic             entrada_ready,
    output logic             saida_valid,
    output logic [WIDTH-1:0] saida,
    input  logic             saida_ready,
    output logic [WIDTH-1:0] mascara,
    output logic             injetado,
    output logic [CNT_W-1:0] total_injetado
);

    logic             valid_q;
    logic [WIDTH-1:0] saida_q;
    logic [WIDTH-1:0] mascara_q;
    logic             injetado_q;
    logic [CNT_W-1:0] total_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    logic             aceita;
    logic             slot;
    logic [WIDTH-1:0] mask_d;
    logic [15:0]      lfsr;
    logic             lfsr_unused;

    int unsigned      pos_n;
    int unsigned      pos_m;
    int unsigned      pos_fim;
    int unsigned      pos_rand;

    assign entrada_ready = !valid_q || saida_ready;
    assign aceita        = entrada_valid && entrada_ready;

    injetor_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .avanca (aceita),
        .estado (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:POS_W];

    // Period slot detection. With periodo=0 every word is a slot. A non-slot
    // word just increments, so a periodo shrunk below cnt_q is only hit after
    // the 8-bit counter wraps.
    always_comb begin
        slot  = (periodo == 8'd0) || (cnt_q == periodo - 8'd1);
        cnt_d = cnt_q + 8'd1;
        if (periodo == 8'd0 || slot) begin
            cnt_d = 8'd0;
        end
    end

    // Mask build: every position is tested against the mode's rule, so
    // out-of-range positions and burst truncation at WIDTH-1 fall out for free.
    always_comb begin
        pos_n    = 32'(n);
        pos_m    = 32'(m);
        pos_fim  = 32'(n) + 32'(burst_len);
        pos_rand = 32'(lfsr[POS_W-1:0]);
        if (pos_rand >= WIDTH) begin
            pos_rand = pos_rand - WIDTH;
        end
        mask_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case (modo)
                MODO_SIMPLES:   mask_d[i] = (i == pos_n);
                MODO_DUPLO:     mask_d[i] = (i == pos_n) || (i == pos_m);
                MODO_RAJADA:    mask_d[i] = (i >= pos_n) && (i < pos_fim);
                MODO_ALEATORIO: mask_d[i] = (i == pos_rand);
                default:        mask_d[i] = 1'b0;
            endcase
        end
        if (!(erro && slot)) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            saida_q    <= '0;
            mascara_q  <= '0;
            injetado_q <= 1'b0;
            total_q    <= '0;
            cnt_q      <= 8'd0;
        end else if (aceita) begin
            valid_q    <= 1'b1;
            saida_q    <= entrada ^ mask_d;
            mascara_q  <= mask_d;
            injetado_q <= |mask_d;
            cnt_q      <= cnt_d;
            if ((|mask_d) && (total_q != '1)) begin
                total_q <= total_q + 1'b1;
            end
        end else if (saida_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign saida_valid    = valid_q;
    assign saida          = saida_q;
    assign mascara        = mascara_q;
    assign injetado       = injetado_q;
    assign total_injetado = total_q;

endmodule

// File: tb/tb_injetor_seq.sv
// ---------------------------------------------------------------------------
// tb_injetor_seq
// Self-checking bench for injetor_seq: directed vector table, hand-written
// multi-cycle sequences, randomized traffic against a behavioural model, and
// a saturation run of the injected-word counter.
// ---------------------------------------------------------------------------
module tb_injetor_seq;

    localparam int unsigned W = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        erro = 1'b0;
    logic [2:0]  modo = 3'd0;
    logic [3:0]  n = 4'd0;
    logic [3:0]  m = 4'd0;
    logic [3:0]  burst_len = 4'd0;
    logic [7:0]  periodo = 8'd0;
    logic        entrada_valid = 1'b0;
    logic [14:0] entrada = '0;
    logic        entrada_ready;
    logic        saida_valid;
    logic [14:0] saida;
    logic        saida_ready = 1'b1;
    logic [14:0] mascara;
    logic        injetado;
    logic [15:0] total_injetado;

    injetor_seq #(
        .WIDTH     (15),
        .POS_W     (4),
        .CNT_W     (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .erro           (erro),
        .modo           (modo),
        .n              (n),
        .m              (m),
        .burst_len      (burst_len),
        .periodo        (periodo),
        .entrada_valid  (entrada_valid),
        .entrada        (entrada),
        .entrada_ready  (entrada_ready),
        .saida_valid    (saida_valid),
        .saida          (saida),
        .saida_ready    (saida_ready),
        .mascara        (mascara),
        .injetado       (injetado),
        .total_injetado (total_injetado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_valid = 1'b0;
    logic [14:0] m_saida = '0;
    logic [14:0] m_mask = '0;
    logic [15:0] m_total = '0;
    logic [7:0]  m_cnt = '0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [14:0] mask_of(input logic e, input logic [2:0] md,
                                            input logic [3:0] pn, input logic [3:0] pm,
                                            input logic [3:0] pb, input logic sl,
                                            input logic [15:0] l);
        int unsigned a;
        int unsigned b;
        int unsigned hi;
        int unsigned p;
        logic [31:0] r;
        a = pn;
        b = pm;
        r = '0;
        if (!e || !sl) return '0;
        case (md)
            3'd1: if (a < W) r = 32'd1 << a;
            3'd2: begin
                if (a < W) r = r | (32'd1 << a);
                if (b < W) r = r | (32'd1 << b);
            end
            3'd3: if (pb != 0 && a < W) begin
                hi = a + pb;
                if (hi > W) hi = W;
                r = (32'd1 << hi) - (32'd1 << a);
            end
            3'd4: begin
                p = l % 16;
                if (p >= W) p = p - W;
                r = 32'd1 << p;
            end
            default: r = '0;
        endcase
        return r[14:0];
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic        acc;
        logic        sl;
        logic [14:0] mk;
        acc = entrada_valid && (!m_valid || saida_ready);
        if (rst) begin
            m_valid = 0; m_saida = '0; m_mask = '0; m_total = '0;
            m_cnt = '0; m_lfsr = 16'hACE1;
        end else if (acc) begin
            sl = (periodo == 0) || (int'(m_cnt) == int'(periodo) - 1);
            mk = mask_of(erro, modo, n, m, burst_len, sl, m_lfsr);
            m_saida = entrada ^ mk;
            m_mask  = mk;
            m_valid = 1;
            if (mk != 0 && m_total != 16'hFFFF) m_total = m_total + 1;
            m_cnt = (periodo == 0 || sl) ? 8'd0 : m_cnt + 8'd1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end else if (saida_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic ev, input logic sr);
        entrada_valid = ev;
        saida_ready   = sr;
        #1;
        if (!rst) chk("entrada_ready", entrada_ready, !m_valid || sr);
        @(posedge clk);
        model_edge();
        #1;
        chk("saida_valid", saida_valid, m_valid);
        chk("saida", saida, m_saida);
        chk("mascara", mascara, m_mask);
        chk("injetado", injetado, m_mask != 0);
        chk("total_injetado", total_injetado, m_total);
    endtask

    task automatic do_reset();
        rst = 1;
        step(0, 1);
        chk("reset_valid", saida_valid, 0);
        chk("reset_saida", saida, 0);
        chk("reset_total", total_injetado, 0);
        rst = 0;
    endtask

    task automatic cfg(input logic e, input logic [2:0] md, input logic [3:0] pn,
                       input logic [3:0] pm, input logic [3:0] pb, input logic [7:0] per);
        erro = e; modo = md; n = pn; m = pm; burst_len = pb; periodo = per;
    endtask

    typedef struct {
        logic        e;
        logic [2:0]  md;
        logic [3:0]  pn;
        logic [3:0]  pm;
        logic [3:0]  pb;
        logic [14:0] din;
        logic [14:0] exp_saida;
        logic [14:0] exp_mask;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int exp_total;

        tbl[0]  = '{1'b0, 3'd1, 4'd14, 4'd0,  4'd0,  15'h0000, 15'h0000, 15'h0000};
        tbl[1]  = '{1'b1, 3'd1, 4'd14, 4'd0,  4'd0,  15'h0000, 15'h4000, 15'h4000};
        tbl[2]  = '{1'b1, 3'd2, 4'd3,  4'd3,  4'd0,  15'h7FFF, 15'h7FF7, 15'h0008};
        tbl[3]  = '{1'b1, 3'd2, 4'd3,  4'd15, 4'd0,  15'h0000, 15'h0008, 15'h0008};
        tbl[4]  = '{1'b1, 3'd2, 4'd2,  4'd9,  4'd0,  15'h0000, 15'h0204, 15'h0204};
        tbl[5]  = '{1'b1, 3'd3, 4'd12, 4'd0,  4'd5,  15'h0000, 15'h7000, 15'h7000};
        tbl[6]  = '{1'b1, 3'd3, 4'd12, 4'd0,  4'd0,  15'h1234, 15'h1234, 15'h0000};
        tbl[7]  = '{1'b1, 3'd1, 4'd15, 4'd0,  4'd0,  15'h0055, 15'h0055, 15'h0000};
        tbl[8]  = '{1'b1, 3'd5, 4'd1,  4'd1,  4'd1,  15'h0000, 15'h0000, 15'h0000};
        tbl[9]  = '{1'b1, 3'd0, 4'd1,  4'd0,  4'd0,  15'h0000, 15'h0000, 15'h0000};
        tbl[10] = '{1'b1, 3'd2, 4'd15, 4'd15, 4'd0,  15'h0000, 15'h0000, 15'h0000};
        tbl[11] = '{1'b1, 3'd3, 4'd0,  4'd0,  4'd15, 15'h0000, 15'h7FFF, 15'h7FFF};
        tbl[12] = '{1'b1, 3'd1, 4'd0,  4'd0,  4'd0,  15'h7FFF, 15'h7FFE, 15'h0001};

        // ---------------- directed vector table ----------------
        do_reset();
        exp_total = 0;
        for (int i = 0; i < 13; i++) begin
            cfg(tbl[i].e, tbl[i].md, tbl[i].pn, tbl[i].pm, tbl[i].pb, 8'd0);
            entrada = tbl[i].din;
            step(1, 1);
            if (tbl[i].exp_mask != 0) exp_total++;
            chk($sformatf("tbl%0d_saida", i), saida, tbl[i].exp_saida);
            chk($sformatf("tbl%0d_mascara", i), mascara, tbl[i].exp_mask);
            chk($sformatf("tbl%0d_injetado", i), injetado, tbl[i].exp_mask != 0);
        end
        chk("tbl_total", total_injetado, exp_total);

        // ---------------- period 4, eight back-to-back words ----------------
        do_reset();
        cfg(1, 3'd1, 4'd0, 4'd0, 4'd0, 8'd4);
        entrada = '0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1);
            chk($sformatf("period_w%0d", k + 1), saida, (k == 3 || k == 7) ? 1 : 0);
        end
        chk("period_total", total_injetado, 2);

        // ---------------- backpressure ----------------
        do_reset();
        cfg(1, 3'd1, 4'd0, 4'd0, 4'd0, 8'd0);
        entrada = 15'h0100;
        step(1, 1);
        chk("bp_first", saida, 15'h0101);
        entrada = 15'h0200;
        for (int k = 0; k < 3; k++) begin
            step(1, 0);
            chk("bp_ready_low", entrada_ready, 0);
            chk("bp_saida_hold", saida, 15'h0101);
            chk("bp_mask_hold", mascara, 15'h0001);
            chk("bp_total_hold", total_injetado, 1);
        end
        step(1, 1);
        chk("bp_second", saida, 15'h0201);
        entrada = 15'h0300;
        step(1, 1);
        chk("bp_third", saida, 15'h0301);
        chk("bp_total", total_injetado, 3);
        step(0, 1);
        chk("bp_drain", saida_valid, 0);

        // ---------------- pseudo-random mode and mid-stream reset ----------------
        do_reset();
        cfg(1, 3'd4, 4'd0, 4'd0, 4'd0, 8'd0);
        entrada = '0;
        step(1, 1);
        chk("rand_w1", mascara, 15'h0002);
        step(1, 1);
        chk("rand_w2", mascara, 15'h0008);
        rst = 1;
        step(1, 1);
        chk("rand_rst_drop", saida_valid, 0);
        rst = 0;
        step(1, 1);
        chk("rand_after_rst", mascara, 15'h0002);

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0 || k == 0) begin
                cfg($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
                    4'($urandom), 4'($urandom), 8'd0);
                case ($urandom_range(0, 3))
                    0: periodo = 8'd0;
                    1: periodo = 8'($urandom_range(1, 4));
                    2: periodo = 8'($urandom_range(1, 9));
                    default: periodo = 8'($urandom);
                endcase
            end
            entrada = 15'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        rst = 0;

        // ---------------- counter saturation ----------------
        do_reset();
        cfg(1, 3'd1, 4'd0, 4'd0, 4'd0, 8'd0);
        entrada = '0;
        entrada_valid = 1;
        saida_ready   = 1;
        for (int k = 0; k < 65534; k++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        chk("sat_pre", total_injetado, 16'hFFFE);
        step(1, 1);
        chk("sat_reach", total_injetado, 16'hFFFF);
        step(1, 1);
        chk("sat_hold", total_injetado, 16'hFFFF);
        chk("sat_injetado", injetado, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
